// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup / EX update bundle for branch_target_buffer
// master drives lookups, updates and flush; slave is the buffer answering with hit/target/stats.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface branch_target_buffer_if #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH
);
  logic                  i_lookup_valid;
  logic [ADDR_WIDTH-1:0] i_lookup_pc;
  logic                  o_hit;
  logic [ADDR_WIDTH-1:0] o_target;
  logic                  i_upd_valid;
  logic [ADDR_WIDTH-1:0] i_upd_pc;
  logic [ADDR_WIDTH-1:0] i_upd_target;
  logic                  i_upd_taken;
  logic                  i_upd_is_jump;
  logic                  i_flush;
  logic [31:0]           o_lookups;
  logic [31:0]           o_hits;

  modport master (
    output i_lookup_valid, i_lookup_pc,
    output i_upd_valid, i_upd_pc, i_upd_target, i_upd_taken, i_upd_is_jump,
    output i_flush,
    input  o_hit, o_target, o_lookups, o_hits
  );

  modport slave (
    input  i_lookup_valid, i_lookup_pc,
    input  i_upd_valid, i_upd_pc, i_upd_target, i_upd_taken, i_upd_is_jump,
    input  i_flush,
    output o_hit, o_target, o_lookups, o_hits
  );
endinterface

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - 2-way set-associative fetch BTB with combinational lookup
// Optional lookup/hit statistics counters are built only when BTB_STATS_EN is defined.
module branch_target_buffer #(
  parameter int SETS       = 16,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_target_buffer_if.slave bus
);
  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;

  logic [SETS-1:0]       valid_q [2];
  logic [SETS-1:0]       lru_q;
  logic [TAG_BITS-1:0]   tag_q    [2][SETS];
  logic [ADDR_WIDTH-1:0] target_q [2][SETS];
  logic [1:0]            cnt_q    [2][SETS];
  logic                  jmp_q    [2][SETS];

  // ---------------- lookup ----------------
  logic [INDEX_BITS-1:0] l_idx;
  logic [TAG_BITS-1:0]   l_tag;
  logic                  l_match0, l_match1;
  logic                  l_pred;
  logic [ADDR_WIDTH-1:0] l_target;
  logic                  hit;

  assign l_idx    = bus.i_lookup_pc[INDEX_BITS+1:2];
  assign l_tag    = bus.i_lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign l_match0 = valid_q[0][l_idx] && (tag_q[0][l_idx] == l_tag);
  assign l_match1 = valid_q[1][l_idx] && (tag_q[1][l_idx] == l_tag);

  always_comb begin
    l_pred   = 1'b0;
    l_target = '0;
    if (l_match0) begin
      l_pred   = jmp_q[0][l_idx] | cnt_q[0][l_idx][1];
      l_target = target_q[0][l_idx];
    end else if (l_match1) begin
      l_pred   = jmp_q[1][l_idx] | cnt_q[1][l_idx][1];
      l_target = target_q[1][l_idx];
    end
  end

  assign hit          = bus.i_lookup_valid & (l_match0 | l_match1) & l_pred;
  assign bus.o_hit    = hit;
  assign bus.o_target = hit ? l_target : '0;

  // ---------------- update ----------------
  logic [INDEX_BITS-1:0] u_idx;
  logic [TAG_BITS-1:0]   u_tag;
  logic                  u_hit0, u_hit1, u_hit;
  logic                  u_up;
  logic                  u_way;
  logic                  do_write;
  logic [1:0]            old_cnt, new_cnt;
  logic [ADDR_WIDTH-1:0] new_target;

  assign u_idx  = bus.i_upd_pc[INDEX_BITS+1:2];
  assign u_tag  = bus.i_upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign u_hit0 = valid_q[0][u_idx] && (tag_q[0][u_idx] == u_tag);
  assign u_hit1 = valid_q[1][u_idx] && (tag_q[1][u_idx] == u_tag);
  assign u_hit  = u_hit0 | u_hit1;
  assign u_up   = bus.i_upd_taken | bus.i_upd_is_jump;

  // Hits train their own way; misses fill the first empty way, else the LRU way.
  always_comb begin
    u_way = 1'b0;
    if (u_hit1) begin
      u_way = 1'b1;
    end else if (!u_hit0) begin
      if (!valid_q[0][u_idx])      u_way = 1'b0;
      else if (!valid_q[1][u_idx]) u_way = 1'b1;
      else                         u_way = lru_q[u_idx];
    end
  end

  assign do_write = bus.i_upd_valid & ~bus.i_flush & (u_hit | u_up);
  assign old_cnt  = cnt_q[u_way][u_idx];

  always_comb begin
    new_cnt    = 2'b10;
    new_target = bus.i_upd_target;
    if (u_hit) begin
      if (u_up) begin
        new_cnt = (old_cnt == 2'b11) ? 2'b11 : old_cnt + 2'd1;
      end else begin
        new_cnt    = (old_cnt == 2'b00) ? 2'b00 : old_cnt - 2'd1;
        new_target = target_q[u_way][u_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else if (bus.i_flush) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else if (do_write) begin
      valid_q[u_way][u_idx] <= 1'b1;
      lru_q[u_idx]          <= ~u_way;
    end
  end

  // Payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (do_write) begin
      tag_q[u_way][u_idx]    <= u_tag;
      target_q[u_way][u_idx] <= new_target;
      cnt_q[u_way][u_idx]    <= new_cnt;
      jmp_q[u_way][u_idx]    <= bus.i_upd_is_jump;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, bus.i_lookup_pc[1:0], bus.i_upd_pc[1:0]};

  // ---------------- statistics ----------------
`ifdef BTB_STATS_EN
  logic [31:0] lookups_q, hits_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookups_q <= '0;
      hits_q    <= '0;
    end else begin
      if (bus.i_lookup_valid && lookups_q != 32'hFFFF_FFFF) lookups_q <= lookups_q + 32'd1;
      if (hit && hits_q != 32'hFFFF_FFFF)                   hits_q    <= hits_q + 32'd1;
    end
  end

  assign bus.o_lookups = lookups_q;
  assign bus.o_hits    = hits_q;
`else
  assign bus.o_lookups = 32'd0;
  assign bus.o_hits    = 32'd0;
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - table-driven scoreboard bench for branch_target_buffer
// Stats expectations follow BTB_STATS_EN.
module tb_branch_target_buffer;
  logic clk;
  logic rst_n;

  branch_target_buffer_if #(.ADDR_WIDTH(32)) bus ();

  branch_target_buffer #(.SETS(16), .ADDR_WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        upd;
    logic        look;
    logic        lv;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    logic        jump;
    logic        exp_hit;
    logic [31:0] exp_tgt;
  } vec_t;

  typedef struct {
    int          id;
    logic        hit;
    logic [31:0] tgt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic upd, input logic look, input logic lv, input logic flush,
                     input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                     input logic jump, input logic exp_hit, input logic [31:0] exp_tgt);
    vec_t v;
    v.upd = upd; v.look = look; v.lv = lv; v.flush = flush; v.pc = pc; v.tgt = tgt;
    v.taken = taken; v.jump = jump; v.exp_hit = exp_hit; v.exp_tgt = exp_tgt;
    vecs.push_back(v);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken, input logic jump);
    add(1'b1, 1'b0, 1'b0, 1'b0, pc, tgt, taken, jump, 1'b0, 32'h0);
  endtask

  task automatic look(input logic [31:0] pc, input logic eh, input logic [31:0] et);
    add(1'b0, 1'b1, 1'b1, 1'b0, pc, 32'h0, 1'b0, 1'b0, eh, et);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_sb();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard empty got hit %0b expected an entry", bus.o_hit);
    end else begin
      e = sb.pop_front();
      if (bus.o_hit !== e.hit || bus.o_target !== e.tgt) begin
        errors++;
        $display("FAIL lookup row %0d got hit %0b target %h expected hit %0b target %h",
                 e.id, bus.o_hit, bus.o_target, e.hit, e.tgt);
      end
    end
  endtask

  task automatic run_row(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    bus.i_upd_valid    = v.upd;
    bus.i_upd_pc       = v.pc;
    bus.i_upd_target   = v.tgt;
    bus.i_upd_taken    = v.taken;
    bus.i_upd_is_jump  = v.jump;
    bus.i_flush        = v.flush;
    bus.i_lookup_valid = v.lv;
    bus.i_lookup_pc    = v.pc;
    if (v.look) begin
      e.id = id; e.hit = v.exp_hit; e.tgt = v.exp_tgt;
      sb.push_back(e);
    end
    #1;
    if (v.look) check_sb();
  endtask

  task automatic idle();
    @(negedge clk);
    bus.i_upd_valid    = 1'b0;
    bus.i_flush        = 1'b0;
    bus.i_lookup_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;
    logic [31:0] exp_lk, exp_ht;

    rst_n = 1'b0;
    bus.i_lookup_valid = 1'b0; bus.i_lookup_pc = '0;
    bus.i_upd_valid = 1'b0; bus.i_upd_pc = '0; bus.i_upd_target = '0;
    bus.i_upd_taken = 1'b0; bus.i_upd_is_jump = 1'b0; bus.i_flush = 1'b0;

    // basic training of one entry
    look(32'h0040_0010, 1'b0, 32'h0);
    upd (32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0);
    look(32'h0040_0010, 1'b1, 32'h0040_0100);
    upd (32'h0040_0010, 32'h0040_0100, 1'b0, 1'b0);
    look(32'h0040_0010, 1'b0, 32'h0);
    upd (32'h0040_0010, 32'h0040_0100, 1'b0, 1'b0);
    upd (32'h0040_0010, 32'h0040_0100, 1'b0, 1'b0);
    look(32'h0040_0010, 1'b0, 32'h0);
    upd (32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0);
    look(32'h0040_0010, 1'b0, 32'h0);
    upd (32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0);
    look(32'h0040_0010, 1'b1, 32'h0040_0100);
    upd (32'h0040_0010, 32'h0040_0180, 1'b1, 1'b0);
    look(32'h0040_0010, 1'b1, 32'h0040_0180);
    upd (32'h0040_0030, 32'h0040_0300, 1'b0, 1'b0);
    look(32'h0040_0030, 1'b0, 32'h0);
    look(32'h0040_0013, 1'b1, 32'h0040_0180);
    add (1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    look(32'h0040_0010, 1'b0, 32'h0);
    // set-4 conflict and LRU eviction
    upd (32'h0040_0010, 32'h0040_0110, 1'b1, 1'b0);
    upd (32'h0040_0050, 32'h0040_0150, 1'b1, 1'b0);
    upd (32'h0040_0010, 32'h0040_0110, 1'b1, 1'b0);
    upd (32'h0040_0090, 32'h0040_0190, 1'b1, 1'b0);
    look(32'h0040_0050, 1'b0, 32'h0);
    look(32'h0040_0010, 1'b1, 32'h0040_0110);
    look(32'h0040_0090, 1'b1, 32'h0040_0190);
    // jump entries and jump-flag clearing
    upd (32'h0040_0020, 32'h0040_0200, 1'b0, 1'b1);
    look(32'h0040_0020, 1'b1, 32'h0040_0200);
    upd (32'h0040_0020, 32'h0040_0200, 1'b0, 1'b1);
    look(32'h0040_0020, 1'b1, 32'h0040_0200);
    upd (32'h0040_0020, 32'h0040_0200, 1'b0, 1'b0);
    look(32'h0040_0020, 1'b1, 32'h0040_0200);
    upd (32'h0040_0020, 32'h0040_0200, 1'b0, 1'b0);
    look(32'h0040_0020, 1'b0, 32'h0);
    // flush beats a same-cycle update
    add (1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0040, 32'h0040_0400, 1'b1, 1'b0, 1'b0, 32'h0);
    look(32'h0040_0040, 1'b0, 32'h0);
    look(32'h0040_0010, 1'b0, 32'h0);
    look(32'h0040_0090, 1'b0, 32'h0);
    // same-cycle lookup+update sees old state; lookup_valid gates hit
    add (1'b1, 1'b1, 1'b1, 1'b0, 32'h0040_0090, 32'h0040_0190, 1'b1, 1'b0, 1'b0, 32'h0);
    look(32'h0040_0090, 1'b1, 32'h0040_0190);
    add (1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0090, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_lookups", bus.o_lookups, 32'h0);
    chk("reset_hits", bus.o_hits, 32'h0);

    for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);
    idle();

    // asynchronous reset in the middle of a hitting lookup
    @(negedge clk);
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_pc    = 32'h0040_0090;
    e.id = 900; e.hit = 1'b1; e.tgt = 32'h0040_0190;
    sb.push_back(e);
    #1 check_sb();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hit", {31'h0, bus.o_hit}, 32'h0);
    chk("async_rst_target", bus.o_target, 32'h0);
    chk("async_rst_lookups", bus.o_lookups, 32'h0);
    chk("async_rst_hits", bus.o_hits, 32'h0);
    bus.i_lookup_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_upd_valid = 1'b1; bus.i_upd_pc = 32'h0040_0010; bus.i_upd_target = 32'h0040_0110;
    bus.i_upd_taken = 1'b1; bus.i_upd_is_jump = 1'b0; bus.i_flush = 1'b0;

    // statistics: 10 lookups, 4 hits
    vecs.delete();
    upd (32'h0040_0050, 32'h0040_0150, 1'b1, 1'b0);
    look(32'h0040_0010, 1'b1, 32'h0040_0110);
    look(32'h0040_0050, 1'b1, 32'h0040_0150);
    look(32'h0040_0090, 1'b0, 32'h0);
    look(32'h0040_0010, 1'b1, 32'h0040_0110);
    look(32'h0040_0030, 1'b0, 32'h0);
    look(32'h0040_0050, 1'b1, 32'h0040_0150);
    look(32'h0040_0060, 1'b0, 32'h0);
    look(32'h0040_0070, 1'b0, 32'h0);
    look(32'h0040_0080, 1'b0, 32'h0);
    look(32'h0040_0094, 1'b0, 32'h0);
    for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], 1000 + i);
    idle();
    #1;
`ifdef BTB_STATS_EN
    exp_lk = 32'd10;
    exp_ht = 32'd4;
`else
    exp_lk = 32'd0;
    exp_ht = 32'd0;
`endif
    chk("stats_lookups", bus.o_lookups, exp_lk);
    chk("stats_hits", bus.o_hits, exp_ht);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
